// File: rtl/dmem_mmio_bridge_if.sv
// Data-memory bus between the processor core and the memory/MMIO bridge.
// The core drives the store strobe, address and store data. The bridge
// returns load data combinationally in the same cycle.
interface dmem_mmio_bridge_if;
  logic        MemWrite_EN;
  logic [31:0] MemAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite_EN, output MemAddr, output WriteData, input ReadData);
  modport slave  (input MemWrite_EN, input MemAddr, input WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data-memory bridge. It decodes core accesses to three targets:
//   - on-chip word RAM,
//   - a UART transmitter (8-entry TX FIFO feeding an 8N1 serialiser),
//   - a free-running 32-bit timer with a sticky compare flag.
// The core has no wait states, so loads are answered combinationally.
module dmem_mmio_bridge #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_mmio_bridge_if.slave     bus,
  output logic                  uart_tx,
  output logic                  timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // ---------------- address decode ----------------
  logic [31:0] word_addr;
  logic        is_ram, sel_txdata, sel_status, sel_count, sel_cmp;

  assign word_addr  = {bus.MemAddr[31:2], 2'b00};
  assign is_ram     = (bus.MemAddr[31] == 1'b0) && (bus.MemAddr < 32'(RAM_WORDS * 4));
  assign sel_txdata = (word_addr == 32'h8000_0000);
  assign sel_status = (word_addr == 32'h8000_0004);
  assign sel_count  = (word_addr == 32'h8000_0008);
  assign sel_cmp    = (word_addr == 32'h8000_000C);

  // ---------------- RAM ----------------
  logic [31:0] ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;

  assign ram_idx = bus.MemAddr[AW+1:2];

  // Store port. Loads read this array asynchronously in the read mux below.
  // NOTE: the RAM array has no reset branch; clearing it would turn the
  // memory into a huge flop bank, and its contents are meant to survive reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite_EN && is_ram) ram[ram_idx] <= bus.WriteData;
  end

  // ---------------- timer ----------------
  logic [31:0] tmr_count, tmr_cmp;
  logic        wr_count, wr_cmp;

  assign wr_count = bus.MemWrite_EN && sel_count;
  assign wr_cmp   = bus.MemWrite_EN && sel_cmp;

  // COUNT free-runs unless loaded. A CMP write clears the flag, and that
  // clear takes priority over a match in the same cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values (the compare below sees the old COUNT and CMP).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_count <= '0;
      tmr_cmp   <= '1;
      timer_irq <= 1'b0;
    end else begin
      tmr_count <= wr_count ? bus.WriteData : tmr_count + 32'd1;
      if (wr_cmp) tmr_cmp <= bus.WriteData;
      if (wr_cmp)                       timer_irq <= 1'b0;
      else if (tmr_count == tmr_cmp)    timer_irq <= 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] fifo_cnt;
  logic       ovf, full, empty, push_req, push, pop;

  assign full     = (fifo_cnt == 4'(FIFO_DEPTH));
  assign empty    = (fifo_cnt == 4'd0);
  assign push_req = bus.MemWrite_EN && sel_txdata;
  // A push while full is still accepted when the serialiser frees a slot
  // in the same cycle.
  assign push     = push_req && (!full || pop);

  // FIFO payload storage. Only the pointers and count need a reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 4'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 4'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !push)                                 ovf <= 1'b1;
      else if (bus.MemWrite_EN && sel_status && bus.WriteData[3]) ovf <= 1'b0;
    end
  end

  // ---------------- serialiser ----------------
  tx_state_t     state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;

  // Serialiser registers. uart_tx is registered from the next-state value,
  // so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      uart_tx <= tx_n;
    end
  end

  // Next-state logic and the line level for the next cycle. Data bits leave
  // from shreg[0], and shreg shifts right at each bit boundary.
  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = 1'b1;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr];
          cyc_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (cyc == LAST_CYC) begin
          cyc_n     = '0;
          bit_cnt_n = '0;
          state_n   = DATA;
          tx_n      = shreg[0];
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (cyc == LAST_CYC) begin
          cyc_n   = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = shreg[1];
          end
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (cyc == LAST_CYC) begin
          cyc_n   = '0;
          state_n = IDLE;
        end else begin
          cyc_n = cyc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- load data ----------------
  logic [31:0] rdata;

  // Combinational read mux. Unmapped addresses and TXDATA read as zero.
  always_comb begin
    rdata = '0;
    if (is_ram)          rdata = ram[ram_idx];
    else if (sel_status) rdata = {24'd0, fifo_cnt, ovf, (state != IDLE), empty, full};
    else if (sel_count)  rdata = tmr_count;
    else if (sel_cmp)    rdata = tmr_cmp;
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Bench for dmem_mmio_bridge (RAM_WORDS=1024, CLKS_PER_BIT=4).
// It runs a table of RAM/decode vectors, hand-written UART, FIFO, timer and
// reset sequences, and a randomized run checked against a behavioural model.
module tb_dmem_mmio_bridge;
  localparam int C = 4;
  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CNT = 32'h8000_0008;
  localparam logic [31:0] A_CMP = 32'h8000_000C;
  localparam logic [31:0] A_NUL = 32'h8000_0010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_tx, timer_irq;
  always #5 clk = ~clk;

  dmem_mmio_bridge_if bus ();

  dmem_mmio_bridge #(.RAM_WORDS(1024), .CLKS_PER_BIT(C), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .uart_tx(uart_tx), .timer_irq(timer_irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite_EN = we;
    bus.MemAddr     = a;
    bus.WriteData   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'd0);
    #1;
    check(name, bus.ReadData, exp);
  endtask

  // UART receiver model. It samples the line mid-bit on falling edges and
  // queues each decoded byte.
  logic [7:0] rx_q[$];
  int         frame_err = 0;
  int         mon_t = 0;
  bit         mon_busy = 1'b0;
  logic [7:0] mon_sh = 8'd0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (uart_tx == 1'b0) begin
        mon_busy = 1'b1;
        mon_t    = 0;
      end
    end else begin
      mon_t++;
      if (mon_t == C / 2 && uart_tx !== 1'b0) frame_err++;
      if (mon_t >= C + C / 2 && mon_t < 9 * C && ((mon_t - C / 2) % C) == 0)
        mon_sh = {uart_tx, mon_sh[7:1]};
      if (mon_t == 9 * C + C / 2) begin
        if (uart_tx !== 1'b1) frame_err++;
        rx_q.push_back(mon_sh);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  logic [31:0] model_mem [int];

  initial begin
    int base;
    int lows;
    logic [39:0] exp_tx;
    logic [31:0] m_cnt, m_cmp;
    logic        m_irq;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 32'h4000_0000, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h1234_5678};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0020, 32'h2222_2222, 1'b1, 32'h1111_1111};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h2222_2222};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hAAAA_5555, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0, 1'b1, 32'hAAAA_5555};
    vecs[12] = '{1'b0, A_TX, 32'h0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, A_NUL, 32'h0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0};
    vecs[15] = '{1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'hDEAD_BEEF};

    // Reset state, observed while reset is held.
    drive(1'b0, A_NUL, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(timer_irq), 32'd0);
    rd("rst_status", A_ST, 32'h0000_0002);
    rd("rst_count", A_CNT, 32'h0);
    rd("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd("rst_txdata", A_TX, 32'h0);
    reset = 1'b1;
    tick();

    // RAM and decode vectors.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), bus.ReadData, vecs[i].exp);
      tick();
    end
    drive(1'b0, A_NUL, 32'd0);
    tick();

    // Single 0xA5 frame, checked bit by bit. Busy is checked alongside.
    for (int i = 0; i < 40; i++) begin
      if (i < C)          exp_tx[i] = 1'b0;
      else if (i < 9 * C) exp_tx[i] = 8'hA5 >> ((i - C) / C);
      else                exp_tx[i] = 1'b1;
    end
    base = rx_q.size();
    drive(1'b1, A_TX, 32'h0000_00A5);
    tick();
    drive(1'b0, A_ST, 32'd0);
    check("a5_pre_pop", 32'(uart_tx), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("a5_tx[%0d]", i), 32'(uart_tx), 32'(exp_tx[i]));
      check($sformatf("a5_busy[%0d]", i), 32'(bus.ReadData[2]), 32'd1);
    end
    tick();
    check("a5_idle_tx", 32'(uart_tx), 32'd1);
    check("a5_idle_status", bus.ReadData, 32'h0000_0002);
    check("a5_rx_cnt", 32'(rx_q.size() - base), 32'd1);
    if (rx_q.size() > base) check("a5_rx_byte", 32'(rx_q[base]), 32'h0000_00A5);

    // Ten back-to-back bytes: one popped, eight queued, the last dropped.
    base = rx_q.size();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, A_TX, 32'(8'h30 + k));
      tick();
    end
    rd("ovf_status", A_ST, 32'h0000_008D);
    drive(1'b1, A_ST, 32'h0000_0008);
    tick();
    rd("ovf_clr_status", A_ST, 32'h0000_0085);
    drive(1'b0, A_NUL, 32'd0);
    for (int i = 0; i < 9 * 41 + 60 && rx_q.size() - base < 9; i++) tick();
    repeat (60) tick();
    check("ovf_rx_cnt", 32'(rx_q.size() - base), 32'd9);
    for (int k = 0; k < 9; k++)
      if (rx_q.size() > base + k) check($sformatf("ovf_rx[%0d]", k), 32'(rx_q[base + k]), 32'(8'h30 + k));
    rd("ovf_drained", A_ST, 32'h0000_0002);

    // Timer wrap, compare and clear priority.
    drive(1'b1, A_CNT, 32'hFFFF_FFFE);
    tick();
    drive(1'b1, A_CMP, 32'h0000_0001);
    tick();
    rd("tmr_cnt_ff", A_CNT, 32'hFFFF_FFFF);
    check("tmr_irq_a", 32'(timer_irq), 32'd0);
    tick();
    check("tmr_cnt_wrap", bus.ReadData, 32'h0);
    tick();
    check("tmr_cnt_1", bus.ReadData, 32'h1);
    check("tmr_irq_b", 32'(timer_irq), 32'd0);
    tick();
    check("tmr_irq_rise", 32'(timer_irq), 32'd1);
    check("tmr_cnt_2", bus.ReadData, 32'h2);
    tick();
    check("tmr_irq_sticky", 32'(timer_irq), 32'd1);
    drive(1'b1, A_CNT, 32'h0);
    tick();
    drive(1'b0, A_CNT, 32'd0);
    tick();
    check("tmr_cnt_eq_cmp", bus.ReadData, 32'h1);
    check("tmr_irq_c", 32'(timer_irq), 32'd1);
    drive(1'b1, A_CMP, 32'h5);
    tick();
    check("tmr_clear_wins", 32'(timer_irq), 32'd0);
    rd("tmr_cmp_5", A_CMP, 32'h5);
    repeat (3) tick();
    check("tmr_irq_d", 32'(timer_irq), 32'd0);
    tick();
    check("tmr_irq_match5", 32'(timer_irq), 32'd1);

    // Randomized run against the behavioural model.
    drive(1'b1, A_CNT, 32'h100);
    tick();
    drive(1'b1, A_CMP, 32'h10C);
    tick();
    m_cnt = 32'h101;
    m_cmp = 32'h10C;
    m_irq = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        we, chk, wr_cnt, wr_cmp, n_irq;
      logic [31:0] a, d, expv;
      int          idx;
      we = 1'b0; chk = 1'b0; expv = 32'd0; a = A_NUL; d = $urandom;
      idx = int'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0, 1: begin we = 1'b1; a = 32'(idx) << 2; end
        2, 3: begin
          a = 32'(idx) << 2;
          if (model_mem.exists(idx)) begin chk = 1'b1; expv = model_mem[idx]; end
        end
        4: begin
          we  = 1'($urandom_range(0, 1));
          a   = ($urandom_range(0, 1) == 0) ? (($urandom | 32'h1000) & 32'h7FFF_FFFC)
                                            : (A_NUL | ($urandom & 32'h7FFF_FFFC));
          chk = 1'b1;
        end
        5: begin a = A_CNT; chk = 1'b1; expv = m_cnt; end
        6: begin we = 1'b1; a = A_CNT; d = m_cmp - 32'($urandom_range(0, 6)); end
        default: begin
          a  = A_CMP;
          we = 1'($urandom_range(0, 1));
          d  = m_cnt + 32'($urandom_range(1, 8));
          if (!we) begin chk = 1'b1; expv = m_cmp; end
        end
      endcase
      drive(we, a, d);
      #1;
      if (chk) check($sformatf("rnd%0d_rdata", n), bus.ReadData, expv);
      check($sformatf("rnd%0d_irq", n), 32'(timer_irq), 32'(m_irq));
      @(posedge clk);
      wr_cnt = we && (a == A_CNT);
      wr_cmp = we && (a == A_CMP);
      if (we && a < 32'h1000) model_mem[int'(a[11:2])] = d;
      n_irq = wr_cmp ? 1'b0 : ((m_cnt == m_cmp) ? 1'b1 : m_irq);
      m_cnt = wr_cnt ? d : m_cnt + 32'd1;
      if (wr_cmp) m_cmp = d;
      m_irq = n_irq;
      #1;
    end

    // Reset in the middle of a frame, with three bytes still queued.
    base = rx_q.size();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, A_TX, 32'(8'h61 + k));
      tick();
    end
    drive(1'b0, A_ST, 32'd0);
    repeat (2 * C + 2) tick();
    #1;
    check("mid_status_pre", bus.ReadData, 32'h0000_0034);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(uart_tx), 32'd1);
    check("mid_rst_irq", 32'(timer_irq), 32'd0);
    rd("mid_rst_status", A_ST, 32'h0000_0002);
    rd("mid_rst_count", A_CNT, 32'h0);
    rd("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
    @(posedge clk);
    #3;
    reset = 1'b1;
    drive(1'b0, A_ST, 32'd0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_tx_quiet", 32'(lows), 32'd0);
    check("post_rst_rx_cnt", 32'(rx_q.size() - base), 32'd0);
    check("post_rst_status", bus.ReadData, 32'h0000_0002);
    check("frame_errors", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
